// File: rtl/norm_pkg.sv
// rtl/norm_pkg.sv - shared constants and types for the LZC normalizer pipeline
package norm_pkg;

    localparam int WIDTH_DEF = 36;
    localparam int EW_DEF    = 7;
    localparam int ADJ_DEF   = 13;
    localparam int EMIN_DEF  = 1;
    localparam int CW_DEF    = $clog2(WIDTH_DEF + 1);

    // Default-width views; the top re-derives both from its own parameters.
    typedef logic signed [EW_DEF+1:0] exp_full_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] mant;
        logic [EW_DEF-1:0]    exp;
        logic                 denorm;
        logic [CW_DEF-1:0]    zc;
        logic                 zero;
    } s1_payload_t;

endpackage

// File: rtl/lzc_tree.sv
// rtl/lzc_tree.sv - combinational leading-zero counter, returns WIDTH for zero input
module lzc_tree #(
    parameter int  WIDTH = 36,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] mant,
    output logic [CW-1:0]    zc
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        zc = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (mant[i]) zc = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/lzc_norm_pipe.sv
// rtl/lzc_norm_pipe.sv - two-stage pipelined leading-zero normalizer with valid/ready
module lzc_norm_pipe
    import norm_pkg::*;
#(
    parameter int  WIDTH = WIDTH_DEF,
    parameter int  EW    = EW_DEF,
    parameter int  ADJ   = ADJ_DEF,
    parameter int  EMIN  = EMIN_DEF,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EW-1:0]    in_exp,
    input  logic             in_denorm_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EW-1:0]    out_exp,
    output logic [CW-1:0]    out_zcnt,
    output logic             out_zero,
    output logic             out_uflow,
    output logic             out_ovfl
);

    typedef logic signed [EW+1:0] exp_t;

    typedef struct packed {
        logic [WIDTH-1:0] mant;
        logic [EW-1:0]    exp;
        logic             denorm;
        logic [CW-1:0]    zc;
        logic             zero;
    } s1_t;

    logic             s1_valid, s2_valid;
    logic             s1_adv, s2_adv;
    logic [CW-1:0]    zc;
    s1_t              s1_q;

    exp_t             e_full, lim;
    logic [CW-1:0]    shamt;
    logic [WIDTH-1:0] n_mant;
    logic [EW-1:0]    n_exp;
    logic             n_uflow, n_ovfl;

    lzc_tree #(.WIDTH(WIDTH)) u_lzc (
        .mant (in_mant),
        .zc   (zc)
    );

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_comb begin
        e_full  = exp_t'(s1_q.exp) + exp_t'(ADJ) - exp_t'(s1_q.zc);
        lim     = exp_t'(s1_q.exp) + exp_t'(ADJ) - exp_t'(EMIN);
        shamt   = s1_q.zc;
        n_exp   = e_full[EW-1:0];
        n_uflow = e_full < exp_t'(EMIN);
        n_ovfl  = e_full > exp_t'((1 << EW) - 1);
        // Denormal mode clamps the shift so the exponent bottoms out at EMIN.
        if (s1_q.denorm) begin
            if (exp_t'(s1_q.zc) > lim) begin
                shamt   = (lim < 0) ? '0 : lim[CW-1:0];
                n_exp   = EW'(EMIN);
                n_uflow = 1'b1;
            end else begin
                n_uflow = 1'b0;
            end
        end
        n_mant = s1_q.mant << shamt;
        if (s1_q.zero) begin
            n_mant  = '0;
            n_exp   = '0;
            n_uflow = 1'b0;
            n_ovfl  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_q      <= '0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_zcnt  <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
            out_ovfl  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= '{mant: in_mant, exp: in_exp, denorm: in_denorm_en,
                              zc: zc, zero: (in_mant == '0)};
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_mant  <= n_mant;
                    out_exp   <= n_exp;
                    out_zcnt  <= s1_q.zc;
                    out_zero  <= s1_q.zero;
                    out_uflow <= n_uflow;
                    out_ovfl  <= n_ovfl;
                end
            end
        end
    end

endmodule
